pll_seq: RTL and testbench
==========================

# pll_seq

Sequencer for the board rPLL: drives its RESET and ODSEL inputs, qualifies its asynchronous LOCK output, and produces the synchronous downstream reset for logic clocked from the PLL output. Sits between the crystal-clock domain and the PLL wrapper. Handles power-up, loss of lock, bounded relock retries and run-time output-divider reconfiguration through a request/ack handshake.

## Interface
- RST_CYCLES, 16: width of each PLL reset pulse, in clk cycles (≥2).
- LOCK_STABLE, 1024: consecutive cycles synchronized lock must stay high before ready.
- LOCK_TIMEOUT, 65536: cycles allowed in WAIT_LOCK before the attempt counts as failed (> LOCK_STABLE).
- MAX_RETRY, 3: failed lock attempts tolerated before FAIL (≥1).
- ODSEL_INIT, 6'd0: pll_odsel value after reset.
- clk  in  1  crystal-domain clock (the PLL input clock); all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pll_lock  in  1  PLL LOCK, asynchronous to clk.
- pll_reset  out  1  PLL RESET, active high.
- pll_odsel  out  6  PLL ODSEL code; changes only while pll_reset=1.
- cfg_req  in  1  level request to apply cfg_odsel.
- cfg_odsel  in  6  requested ODSEL code, valid while cfg_req=1.
- cfg_ack  out  1  one-cycle pulse: request accepted, cfg_odsel captured.
- ready  out  1  PLL locked and qualified.
- sys_rst_n  out  1  downstream reset, low until ready; ready delayed one cycle.
- fail  out  1  retries exhausted; sticky until rst_n or an accepted cfg_req.
- relock_cnt  out  8  saturating count of lock losses in RUN.

## Operation
- Reset values: pll_reset=1, pll_odsel=ODSEL_INIT, cfg_ack=0, ready=0, sys_rst_n=0, fail=0, relock_cnt=0, state=RESET, retry=0, counters=0.
- pll_lock passes a 2-FF synchronizer (lock_s) before any use.
- One shared cycle counter; width = $clog2(LOCK_TIMEOUT+1). A separate stable counter clears whenever lock_s=0.
- RESET: pll_reset=1. Count RST_CYCLES, then go to WAIT_LOCK and clear counters.
- WAIT_LOCK: pll_reset=0. Stable counter increments while lock_s=1.
  - If it reaches LOCK_STABLE-1 with lock_s=1: go to RUN, clear retry.
  - Otherwise, if the cycle counter reaches LOCK_TIMEOUT-1: retry+1. If the new retry equals MAX_RETRY, go to FAIL; else go to RESET.
  - Stable success and timeout in the same cycle: success wins.
- RUN: ready=1.
  - lock_s=0: relock_cnt+1 (saturates at 255), go to RESET, ready drops the next cycle.
  - cfg_req=1: see handshake.
- FAIL: pll_reset=1, fail=1, ready=0. Leaves only via cfg_req or rst_n.
- Handshake:
  - cfg_req is sampled only in RUN or FAIL; elsewhere it is held pending, with no ack.
  - On acceptance: cfg_ack=1 for exactly one cycle, pll_odsel<=cfg_odsel, retry=0, fail=0, go to RESET.
  - The requester drops cfg_req after ack. cfg_req still high two or more cycles after ack is a new request.
- In RUN, cfg_req and lock loss in the same cycle: cfg wins and relock_cnt does not increment.
- rst_n asserted mid-sequence: all outputs return to reset values immediately (asynchronously). pll_odsel reverts to ODSEL_INIT.

## Timing
- Power-up, ideal lock: pll_reset high for RST_CYCLES cycles after rst_n release. ready rises at most 2+LOCK_STABLE cycles after pll_lock rises (synchronizer plus qualification). sys_rst_n rises one cycle after ready.
- Lock loss: ready falls 3 cycles after pll_lock falls (2 sync + 1 state). sys_rst_n falls one cycle later. pll_reset rises in the same cycle ready falls.
- cfg_ack is asserted in the cycle after cfg_req is sampled high in RUN/FAIL. pll_odsel and pll_reset update in that same cycle.
- pll_odsel never changes while pll_reset=0.

## Structure
- Package pll_seq_pkg: state enum (RESET, WAIT_LOCK, RUN, FAIL), the counter-width constant function, and the RELOCK_MAX=8'hFF constant.
- Sub-module sync2: generic 2-FF synchronizer with asynchronous active-low reset to 0, used for pll_lock.

## Test plan
Parameters for all scenarios: RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, MAX_RETRY=2.
- Power-up: release rst_n, raise pll_lock 10 cycles later and hold it -> pll_reset high for 4 cycles; ready=1 exactly 10 cycles after pll_lock rises; sys_rst_n=1 one cycle after ready.
- Lock glitch during qualification: pll_lock high 5 cycles, low 1, then high -> ready waits for 8 fresh stable cycles; no retry is counted.
- Loss in RUN: drop pll_lock for 3 cycles -> ready=0 three cycles after the fall, relock_cnt=1, new 4-cycle reset pulse, then relock.
- Never lock: pll_lock held 0 -> two 32-cycle WAIT_LOCK windows, then fail=1 with pll_reset=1 held. Then cfg_req with cfg_odsel=6'd8 -> single cfg_ack, pll_odsel=8, fail=0, sequence restarts.
- Reconfig in RUN: cfg_req with cfg_odsel=6'd4 and lock loss in the same cycle -> one cfg_ack, pll_odsel=4 while pll_reset=1, relock_cnt unchanged.
- Reset mid-WAIT_LOCK after a reconfig: assert rst_n low -> pll_odsel=0, pll_reset=1, ready=0, fail=0 immediately.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the rPLL sequencer.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    ST_RESET     = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RUN       = 2'd2,
    ST_FAIL      = 2'd3
  } state_e;

  localparam logic [7:0] RELOCK_MAX = 8'hFF;

  // Bits needed to hold values 0..max_val; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pll_seq_sync2.sv
// Generic two-flop synchronizer, asynchronously cleared to zero.
module sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_seq.sv
// rPLL sequencer: reset pulses, lock qualification with bounded retries,
// ODSEL reconfiguration handshake and the downstream synchronous reset.
module pll_seq
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  parameter int unsigned MAX_RETRY    = 3,
  parameter logic [5:0]  ODSEL_INIT   = 6'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] pll_odsel,
  input  logic       cfg_req,
  input  logic [5:0] cfg_odsel,
  output logic       cfg_ack,
  output logic       ready,
  output logic       sys_rst_n,
  output logic       fail,
  output logic [7:0] relock_cnt
);

  localparam int unsigned CW = cnt_width(LOCK_TIMEOUT);
  localparam int unsigned SW = cnt_width(LOCK_STABLE);
  localparam int unsigned RW = cnt_width(MAX_RETRY);

  localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] STABLE_LAST  = SW'(LOCK_STABLE - 1);
  localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRY);

  logic lock_s;

  sync2 #(.WIDTH(1)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  state_e        state_q,      state_d;
  logic [CW-1:0] cnt_q,        cnt_d;
  logic [SW-1:0] stable_q,     stable_d;
  logic [RW-1:0] retry_q,      retry_d;
  logic [5:0]    odsel_q,      odsel_d;
  logic [7:0]    relock_q,     relock_d;
  logic          pll_reset_q,  pll_reset_d;
  logic          ack_q,        ack_d;
  logic          ready_q,      ready_d;
  logic          sys_rst_n_q,  sys_rst_n_d;
  logic          fail_q,       fail_d;
  logic          accept;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = '0;
    retry_d  = retry_q;
    odsel_d  = odsel_q;
    relock_d = relock_q;
    ack_d    = 1'b0;
    accept   = 1'b0;

    case (state_q)
      ST_RESET: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        cnt_d    = cnt_q + 1'b1;
        stable_d = lock_s ? stable_q + 1'b1 : '0;
        // A qualified lock takes priority over a coincident timeout.
        if (lock_s && (stable_q == STABLE_LAST)) begin
          state_d  = ST_RUN;
          retry_d  = '0;
          cnt_d    = '0;
          stable_d = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_d  = retry_q + 1'b1;
          cnt_d    = '0;
          stable_d = '0;
          state_d  = (retry_d == RETRY_LIMIT) ? ST_FAIL : ST_RESET;
        end
      end
      ST_RUN: begin
        if (cfg_req) begin
          accept = 1'b1;
        end else if (!lock_s) begin
          if (relock_q != RELOCK_MAX) relock_d = relock_q + 1'b1;
          state_d = ST_RESET;
          cnt_d   = '0;
        end
      end
      ST_FAIL: begin
        if (cfg_req) accept = 1'b1;
      end
      default: begin
        state_d = ST_RESET;
        cnt_d   = '0;
      end
    endcase

    if (accept) begin
      ack_d   = 1'b1;
      odsel_d = cfg_odsel;
      retry_d = '0;
      state_d = ST_RESET;
      cnt_d   = '0;
    end

    // Outputs follow the next state so they switch on the same edge as it.
    pll_reset_d = (state_d == ST_RESET) || (state_d == ST_FAIL);
    ready_d     = (state_d == ST_RUN);
    fail_d      = (state_d == ST_FAIL);
    sys_rst_n_d = ready_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RESET;
      cnt_q       <= '0;
      stable_q    <= '0;
      retry_q     <= '0;
      odsel_q     <= ODSEL_INIT;
      relock_q    <= '0;
      pll_reset_q <= 1'b1;
      ack_q       <= 1'b0;
      ready_q     <= 1'b0;
      sys_rst_n_q <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stable_q    <= stable_d;
      retry_q     <= retry_d;
      odsel_q     <= odsel_d;
      relock_q    <= relock_d;
      pll_reset_q <= pll_reset_d;
      ack_q       <= ack_d;
      ready_q     <= ready_d;
      sys_rst_n_q <= sys_rst_n_d;
      fail_q      <= fail_d;
    end
  end

  assign pll_reset  = pll_reset_q;
  assign pll_odsel  = odsel_q;
  assign cfg_ack    = ack_q;
  assign ready      = ready_q;
  assign sys_rst_n  = sys_rst_n_q;
  assign fail       = fail_q;
  assign relock_cnt = relock_q;

endmodule

// File: tb/tb_pll_seq.sv
// Directed bench for pll_seq with small timing parameters; every expected
// value below is a hand-computed cycle position relative to a stimulus edge.
module tb_pll_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_lock;
  logic       pll_reset;
  logic [5:0] pll_odsel;
  logic       cfg_req;
  logic [5:0] cfg_odsel;
  logic       cfg_ack;
  logic       ready;
  logic       sys_rst_n;
  logic       fail;
  logic [7:0] relock_cnt;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  pll_seq #(
    .RST_CYCLES   (4),
    .LOCK_STABLE  (8),
    .LOCK_TIMEOUT (32),
    .MAX_RETRY    (2),
    .ODSEL_INIT   (6'd0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_lock   (pll_lock),
    .pll_reset  (pll_reset),
    .pll_odsel  (pll_odsel),
    .cfg_req    (cfg_req),
    .cfg_odsel  (cfg_odsel),
    .cfg_ack    (cfg_ack),
    .ready      (ready),
    .sys_rst_n  (sys_rst_n),
    .fail       (fail),
    .relock_cnt (relock_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges; leaves time at 1 unit past the last edge.
  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    pll_lock  = 1'b0;
    cfg_req   = 1'b0;
    cfg_odsel = 6'd0;
    ticks(3);

    chk("rst_pll_reset", pll_reset, 1);
    chk("rst_odsel", pll_odsel, 0);
    chk("rst_ack", cfg_ack, 0);
    chk("rst_ready", ready, 0);
    chk("rst_sys_rst_n", sys_rst_n, 0);
    chk("rst_fail", fail, 0);
    chk("rst_relock", relock_cnt, 0);

    // Power-up: reset pulse of 4 cycles, lock 10 cycles after release.
    rst_n = 1'b1;
    ticks(1);  chk("pu_reset_e1", pll_reset, 1);
    ticks(2);  chk("pu_reset_e3", pll_reset, 1);
    ticks(1);  chk("pu_reset_e4", pll_reset, 0);
    ticks(6);
    pll_lock = 1'b1;
    ticks(9);  chk("pu_ready_early", ready, 0);
    ticks(1);  chk("pu_ready", ready, 1);
               chk("pu_sysrst_lag", sys_rst_n, 0);
    ticks(1);  chk("pu_sysrst", sys_rst_n, 1);
               chk("pu_odsel", pll_odsel, 0);
               chk("pu_fail", fail, 0);

    // Loss in RUN: lock low for 3 cycles.
    pll_lock = 1'b0;
    ticks(1);  chk("loss_ready_e1", ready, 1);
    ticks(1);  chk("loss_ready_e2", ready, 1);
    ticks(1);  chk("loss_ready_e3", ready, 0);
               chk("loss_reset_e3", pll_reset, 1);
               chk("loss_relock", relock_cnt, 1);
               chk("loss_sysrst_e3", sys_rst_n, 1);
    pll_lock = 1'b1;
    ticks(1);  chk("loss_sysrst_e4", sys_rst_n, 0);
    ticks(2);  chk("loss_reset_e6", pll_reset, 1);
    ticks(1);  chk("loss_reset_e7", pll_reset, 0);
    ticks(7);  chk("loss_relock_early", ready, 0);
    ticks(1);  chk("loss_relocked", ready, 1);

    // Reset while running, then a lock glitch during qualification.
    rst_n    = 1'b0;
    pll_lock = 1'b0;
    #1;
    chk("async_relock_clr", relock_cnt, 0);
    chk("async_ready_clr", ready, 0);
    ticks(1);
    rst_n = 1'b1;
    ticks(4);  chk("gl_wait_entry", pll_reset, 0);
    pll_lock = 1'b1;
    ticks(5);
    pll_lock = 1'b0;
    ticks(1);
    pll_lock = 1'b1;
    ticks(4);  chk("gl_no_early_ready", ready, 0);
    ticks(5);  chk("gl_ready_f15", ready, 0);
    ticks(1);  chk("gl_ready_f16", ready, 1);
               chk("gl_fail", fail, 0);

    // Never lock: two 32-cycle windows, then sticky fail.
    pll_lock = 1'b0;
    ticks(3);  chk("nl_ready_drop", ready, 0);
               chk("nl_relock", relock_cnt, 1);
    ticks(35); chk("nl_win1_end", pll_reset, 0);
    ticks(1);  chk("nl_retry_reset", pll_reset, 1);
               chk("nl_fail_early", fail, 0);
    ticks(3);  chk("nl_retry_reset_e4", pll_reset, 1);
    ticks(1);  chk("nl_win2_start", pll_reset, 0);
    ticks(31); chk("nl_win2_end_fail", fail, 0);
    ticks(1);  chk("nl_fail", fail, 1);
               chk("nl_fail_reset", pll_reset, 1);
               chk("nl_fail_ready", ready, 0);
    ticks(5);  chk("nl_fail_sticky", fail, 1);
               chk("nl_fail_reset_held", pll_reset, 1);
               chk("nl_fail_no_ack", cfg_ack, 0);

    // Recover from FAIL with a reconfiguration request.
    cfg_req   = 1'b1;
    cfg_odsel = 6'd8;
    ticks(1);  chk("fc_ack", cfg_ack, 1);
               chk("fc_odsel", pll_odsel, 8);
               chk("fc_fail_clr", fail, 0);
               chk("fc_reset", pll_reset, 1);
    cfg_req   = 1'b0;
    cfg_odsel = 6'd0;
    ticks(1);  chk("fc_ack_single", cfg_ack, 0);
               chk("fc_odsel_hold", pll_odsel, 8);
    ticks(2);  chk("fc_reset_e4", pll_reset, 1);
    ticks(1);  chk("fc_reset_e5", pll_reset, 0);
    pll_lock = 1'b1;
    ticks(9);  chk("fc_ready_early", ready, 0);
    ticks(1);  chk("fc_ready", ready, 1);
               chk("fc_relock", relock_cnt, 1);

    // Reconfig in RUN coinciding with lock loss: cfg wins.
    pll_lock = 1'b0;
    ticks(2);  chk("rc_odsel_before", pll_odsel, 8);
               chk("rc_ready_before", ready, 1);
    cfg_req   = 1'b1;
    cfg_odsel = 6'd4;
    ticks(1);  chk("rc_ack", cfg_ack, 1);
               chk("rc_odsel", pll_odsel, 4);
               chk("rc_reset", pll_reset, 1);
               chk("rc_ready", ready, 0);
               chk("rc_relock_same", relock_cnt, 1);
    cfg_req = 1'b0;
    ticks(1);  chk("rc_ack_single", cfg_ack, 0);
               chk("rc_relock_after", relock_cnt, 1);
    ticks(4);  chk("rc_wait_entry", pll_reset, 0);

    // Reset asserted mid-WAIT_LOCK after the reconfig.
    rst_n = 1'b0;
    #1;
    chk("mid_odsel", pll_odsel, 0);
    chk("mid_reset", pll_reset, 1);
    chk("mid_ready", ready, 0);
    chk("mid_fail", fail, 0);
    chk("mid_sysrst", sys_rst_n, 0);
    chk("mid_relock", relock_cnt, 0);
    ticks(1);
    rst_n = 1'b1;
    ticks(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
